// File: rtl/pn_mon_if.sv
// pn_mon_if: sampled stepper outputs in, monitor status and LED drive out.
interface pn_mon_if #(
   parameter int TOK_W  = 8,
   parameter int IDX_W  = 8,
   parameter int STEP_W = 16
);
   logic [TOK_W-1:0]  place_tok;
   logic [IDX_W-1:0]  fire_idx;
   logic              restart;
   logic [5:0]        led;
   logic              done;
   logic [TOK_W-1:0]  final_tok;
   logic [STEP_W-1:0] step_cnt;
   logic              dec_err;
   modport master (output place_tok, fire_idx, restart, input led, done, final_tok, step_cnt, dec_err);
   modport slave  (input place_tok, fire_idx, restart, output led, done, final_tok, step_cnt, dec_err);
endinterface

// File: rtl/pn_output_monitor.sv
// pn_output_monitor: counts Petri-net firings, detects quiescence, latches final marking
// and blinks it on active-low LEDs while done.
module pn_output_monitor #(
   parameter int TOK_W        = 8,
   parameter int IDX_W        = 8,
   parameter int IDLE_CODE    = 34,
   parameter int QUIET_CYCLES = 4,
   parameter int STEP_W       = 16,
   parameter int BLINK_DIV    = 13500000
) (
   input logic    clk,
   input logic    rst_n,
   pn_mon_if.slave m
);
   localparam int QW = $clog2(QUIET_CYCLES + 1);
   localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
   typedef enum logic {RUN, DONE} state_t;
   state_t            state, state_n;
   logic [QW-1:0]     quiet, quiet_n;
   logic [BW-1:0]     blink, blink_n;
   logic              phase, phase_n;
   logic [STEP_W-1:0] step_cnt, step_n;
   logic [TOK_W-1:0]  final_tok, final_n, prev_tok;
   logic [5:0]        led, led_n;
   logic              dec_err, dec_err_n, idle, wrap;
   assign m.led       = led;
   assign m.done      = state == DONE;
   assign m.final_tok = final_tok;
   assign m.step_cnt  = step_cnt;
   assign m.dec_err   = dec_err;
   always_comb begin
      idle      = m.fire_idx == IDX_W'(IDLE_CODE);
      wrap      = blink == BW'(BLINK_DIV - 1);
      state_n   = state;
      quiet_n   = quiet;
      step_n    = step_cnt;
      final_n   = final_tok;
      blink_n   = blink;
      phase_n   = phase;
      led_n     = ~m.place_tok[5:0];
      dec_err_n = dec_err | (m.place_tok < prev_tok);
      if (m.restart) begin
         state_n   = RUN;
         quiet_n   = '0;
         step_n    = '0;
         blink_n   = '0;
         phase_n   = 1'b0;
         dec_err_n = 1'b0;
      end else if (state == RUN) begin
         if (!idle) begin
            step_n  = step_cnt + STEP_W'(step_cnt != '1);
            quiet_n = '0;
         end else begin
            quiet_n = quiet + QW'(1);
            if (quiet_n == QW'(QUIET_CYCLES)) begin
               state_n = DONE;
               final_n = m.place_tok;
               blink_n = '0;
               phase_n = 1'b0;
            end
         end
      end else begin
         // led follows the phase it is about to enter so both change on the same edge
         blink_n = wrap ? '0 : blink + BW'(1);
         phase_n = wrap ? ~phase : phase;
         led_n   = phase_n ? 6'h3F : ~final_tok[5:0];
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RUN;
         quiet     <= '0;
         step_cnt  <= '0;
         final_tok <= '0;
         blink     <= '0;
         phase     <= 1'b0;
         led       <= 6'h3F;
         dec_err   <= 1'b0;
         prev_tok  <= '0;
      end else begin
         state     <= state_n;
         quiet     <= quiet_n;
         step_cnt  <= step_n;
         final_tok <= final_n;
         blink     <= blink_n;
         phase     <= phase_n;
         led       <= led_n;
         dec_err   <= dec_err_n;
         prev_tok  <= m.place_tok;
      end
   end
endmodule

// File: tb/tb_pn_output_monitor.sv
// tb_pn_output_monitor: table-driven vectors plus hand sequences for saturation,
// restart priority and asynchronous reset during DONE.
module tb_pn_output_monitor;
   localparam int IDLE = 34;
   typedef struct {
      bit rs; int tok; int idx;
      bit dn; int st; int ld; bit de; int fi;
   } vec_t;
   logic clk = 1'b0, rst_n = 1'b0;
   int tests = 0, fails = 0;
   vec_t tv[$];
   pn_mon_if #(.TOK_W(8), .IDX_W(8), .STEP_W(4)) bus ();
   pn_output_monitor #(
      .TOK_W(8), .IDX_W(8), .IDLE_CODE(IDLE), .QUIET_CYCLES(4), .STEP_W(4), .BLINK_DIV(4)
   ) dut (.clk(clk), .rst_n(rst_n), .m(bus.slave));
   always #5 clk = ~clk;
   task automatic chk(string name, int act, int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic drive(bit rs, int tok, int idx);
      @(negedge clk);
      bus.restart   = rs;
      bus.place_tok = 8'(tok);
      bus.fire_idx  = 8'(idx);
      @(posedge clk);
      #1;
   endtask
   task automatic v(bit rs, int tok, int idx, bit dn, int st, int ld, bit de, int fi);
      tv.push_back('{rs, tok, idx, dn, st, ld, de, fi});
   endtask
   task automatic chk_all(string tag, bit dn, int st, int ld, bit de, int fi);
      chk({tag, " done"}, int'(bus.done), int'(dn));
      chk({tag, " step_cnt"}, int'(bus.step_cnt), st);
      chk({tag, " led"}, int'(bus.led), ld);
      chk({tag, " dec_err"}, int'(bus.dec_err), int'(de));
      chk({tag, " final_tok"}, int'(bus.final_tok), fi);
   endtask
   initial begin
      // steps then quiescence, blink with final 5, firing ignored in DONE
      v(0,5,0,   0,1,'h3A,0,0); v(0,5,1,   0,2,'h3A,0,0); v(0,5,2,   0,3,'h3A,0,0);
      v(0,5,IDLE,0,3,'h3A,0,0); v(0,5,IDLE,0,3,'h3A,0,0); v(0,5,IDLE,0,3,'h3A,0,0);
      v(0,5,IDLE,1,3,'h3A,0,5);
      v(0,5,5,   1,3,'h3A,0,5); v(0,5,IDLE,1,3,'h3A,0,5); v(0,5,IDLE,1,3,'h3A,0,5);
      v(0,5,IDLE,1,3,'h3F,0,5); v(0,5,IDLE,1,3,'h3F,0,5); v(0,5,IDLE,1,3,'h3F,0,5);
      v(0,5,IDLE,1,3,'h3F,0,5); v(0,5,IDLE,1,3,'h3A,0,5);
      // restart leaves final_tok; idle runs of 3 broken by a firing
      v(1,5,IDLE,0,0,'h3A,0,5);
      v(0,5,IDLE,0,0,'h3A,0,5); v(0,5,IDLE,0,0,'h3A,0,5); v(0,5,IDLE,0,0,'h3A,0,5);
      v(0,5,7,   0,1,'h3A,0,5);
      v(0,5,IDLE,0,1,'h3A,0,5); v(0,5,IDLE,0,1,'h3A,0,5); v(0,5,IDLE,0,1,'h3A,0,5);
      // decrease is sticky until restart
      v(0,3,9,   0,2,'h3C,1,5); v(0,2,9,   0,3,'h3D,1,5); v(1,2,9,   0,0,'h3D,0,5);
      // quiescence with final 2, blink 3D/3F
      v(0,2,IDLE,0,0,'h3D,0,5); v(0,2,IDLE,0,0,'h3D,0,5); v(0,2,IDLE,0,0,'h3D,0,5);
      v(0,2,IDLE,1,0,'h3D,0,2);
      v(0,2,IDLE,1,0,'h3D,0,2); v(0,2,IDLE,1,0,'h3D,0,2); v(0,2,IDLE,1,0,'h3D,0,2);
      v(0,2,5,   1,0,'h3F,0,2); v(0,2,IDLE,1,0,'h3F,0,2); v(0,2,IDLE,1,0,'h3F,0,2);
      v(0,2,IDLE,1,0,'h3F,0,2); v(0,2,IDLE,1,0,'h3D,0,2);
      // decrease while DONE, then restart
      v(0,1,IDLE,1,0,'h3D,1,2); v(1,1,IDLE,0,0,'h3E,0,2);
      // 255 -> 0 has no wrap exemption
      v(0,255,0, 0,1,'h00,0,2); v(0,0,0,   0,2,'h3F,1,2); v(0,0,0,   0,3,'h3F,1,2);
      // decrease on the DONE-entry edge
      v(1,0,IDLE,0,0,'h3F,0,2);
      v(0,8,IDLE,0,0,'h37,0,2); v(0,8,IDLE,0,0,'h37,0,2); v(0,8,IDLE,0,0,'h37,0,2);
      v(0,7,IDLE,1,0,'h38,1,7);
      v(1,7,IDLE,0,0,'h38,0,7);
      bus.restart = 1'b0; bus.place_tok = '0; bus.fire_idx = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.place_tok = 8'($urandom);
         bus.fire_idx  = 8'($urandom);
         bus.restart   = 1'($urandom);
      end
      @(posedge clk);
      #1;
      chk_all("reset", 0, 0, 'h3F, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.restart = 1'b1; bus.place_tok = '0; bus.fire_idx = '0;
      @(posedge clk);
      #1;
      for (int i = 0; i < tv.size(); i++) begin
         drive(tv[i].rs, tv[i].tok, tv[i].idx);
         chk_all($sformatf("vec%0d", i), tv[i].dn, tv[i].st, tv[i].ld, tv[i].de, tv[i].fi);
      end
      for (int i = 1; i <= 20; i++) begin
         drive(0, 7, 1);
         chk($sformatf("sat%0d step_cnt", i), int'(bus.step_cnt), i < 15 ? i : 15);
      end
      for (int i = 0; i < 3; i++) drive(0, 7, IDLE);
      chk("pre-restart done", int'(bus.done), 0);
      drive(1, 7, IDLE);
      chk("restart prio done", int'(bus.done), 0);
      chk("restart prio step_cnt", int'(bus.step_cnt), 0);
      drive(0, 7, IDLE);
      chk("after restart done", int'(bus.done), 0);
      for (int i = 0; i < 3; i++) drive(0, 7, IDLE);
      chk("requiesce done", int'(bus.done), 1);
      chk("requiesce final_tok", int'(bus.final_tok), 7);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_all("async reset", 0, 0, 'h3F, 0, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
